// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path and the downstream digit counter stage:
// state encodings, default timing parameters and the prescaler wrap helper.
package stopwatch_pkg;

    localparam int CLK_DIV_DEF    = 500000;
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int CNT_W          = 19;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Modulo increment: returns 0 after reaching last, otherwise cnt + 1.
    function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] cnt,
                                                      input logic [CNT_W-1:0] last);
        if (cnt == last) begin
            return {CNT_W{1'b0}};
        end else begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, consecutive-cycle debounce filter
// and a one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] deb_cnt_d;
    logic          press_q;
    logic          press_d;

    // Debounce filter: any cycle where the input agrees with the level restarts the count.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = {DW{1'b0}};
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d   = sync2_q;
                deb_cnt_d = {DW{1'b0}};
            end else begin
                level_d   = level_q;
                deb_cnt_d = deb_cnt_q + DW'(1'b1);
            end
        end else begin
            level_d   = level_q;
            deb_cnt_d = {DW{1'b0}};
        end
        press_d = level_d & ~level_q;
    end

    // Synchronizer, filter and pulse state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= {DW{1'b0}};
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: IDLE/RUN/PAUSE state machine driven by debounced start and clear
// buttons, plus the 10 ms prescaler that feeds the digit counter stage.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             btn_clear,
    output logic [CNT_W-1:0] sec_count,
    output logic             stop,
    output logic             running,
    output logic             tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic             start_level_s;
    logic             clear_level_s;
    logic             start_press_s;
    logic             clear_press_s;
    logic             unused_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_start),
        .level  (start_level_s),
        .press  (start_press_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear_deb (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_clear),
        .level  (clear_level_s),
        .press  (clear_press_s)
    );

    assign unused_s = start_level_s ^ clear_level_s;

    // Next state: clear overrides start; start toggles between RUN and PAUSE.
    always_comb begin
        state_d = state_q;
        if (clear_press_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_press_s) state_d = ST_RUN;
                    else               state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (start_press_s) state_d = ST_PAUSE;
                    else               state_d = ST_RUN;
                end
                ST_PAUSE: begin
                    if (start_press_s) state_d = ST_RUN;
                    else               state_d = ST_PAUSE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler advances only while RUN is the current state, so resume continues seamlessly.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == ST_IDLE) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_wrap_inc(cnt_q, CNT_LAST);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Control state and prescaler registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; the prescaler is hidden outside RUN.
    assign running   = (state_q == ST_RUN);
    assign stop      = (state_q == ST_IDLE);
    assign sec_count = running ? cnt_q : {CNT_W{1'b0}};
    assign tick      = running && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=10 and DEB_CYCLES=4.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int CLK_DIV = 10;
    localparam int DEB     = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic [18:0] sec_count;
    logic        stop;
    logic        running;
    logic        tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_DIV(CLK_DIV), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .sec_count (sec_count),
        .stop      (stop),
        .running   (running),
        .tick      (tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sec(input string tag, input int val);
        int k;
        k = 0;
        while (sec_count != 19'(val) && k < 30) begin
            step();
            k++;
        end
        check_eq(tag, sec_count, val);
    endtask

    initial begin
        // Reset asserted with buttons idle
        #2;
        check_eq("rst_stop", stop, 1);
        check_eq("rst_sec", sec_count, 0);
        check_eq("rst_tick", tick, 0);
        check_eq("rst_running", running, 0);
        repeat (3) step();
        reset = 1'b1;
        step();
        check_eq("idle_state", dut.state_q, ST_IDLE);
        check_eq("idle_stop", stop, 1);

        // Start held 8 cycles: press on cycle 6, RUN from cycle 7, full count and wrap
        btn_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_eq($sformatf("start_press_%0d", k), dut.start_press_s, (k == 6) ? 1 : 0);
            if (k >= 7) begin
                check_eq($sformatf("run_running_%0d", k), running, 1);
                check_eq($sformatf("run_sec_%0d", k), sec_count, (k - 7) % 10);
                check_eq($sformatf("run_tick_%0d", k), tick, ((k - 7) % 10 == 9) ? 1 : 0);
            end
            if (k == 8) btn_start = 1'b0;
        end

        // 3-cycle glitch while running: no press, counting undisturbed (3 + 13 -> 6)
        btn_start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            check_eq($sformatf("glitch_press_%0d", k), dut.start_press_s, 0);
            if (k == 3) btn_start = 1'b0;
        end
        check_eq("glitch_state", dut.state_q, ST_RUN);
        check_eq("glitch_sec", sec_count, 6);

        // Pause with the held count at 7
        wait_sec("pause_sync", 0);
        btn_start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) btn_start = 1'b0;
        end
        check_eq("pause_state", dut.state_q, ST_PAUSE);
        check_eq("pause_running", running, 0);
        check_eq("pause_stop", stop, 0);
        check_eq("pause_sec", sec_count, 0);
        check_eq("pause_cnt", dut.cnt_q, 7);
        repeat (10) step();
        check_eq("pause_hold_cnt", dut.cnt_q, 7);
        check_eq("pause_hold_tick", tick, 0);

        // Resume from 7: tick after two more cycles, then wrap
        btn_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 6) btn_start = 1'b0;
            if (k >= 7) begin
                check_eq($sformatf("resume_sec_%0d", k), sec_count, k % 10);
                check_eq($sformatf("resume_tick_%0d", k), tick, (k == 9) ? 1 : 0);
            end
        end
        repeat (4) step();

        // Coincident start and clear from RUN: clear wins
        btn_start = 1'b1;
        btn_clear = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) begin
                check_eq("both_start_press", dut.start_press_s, 1);
                check_eq("both_clear_press", dut.clear_press_s, 1);
                btn_start = 1'b0;
                btn_clear = 1'b0;
            end
        end
        check_eq("both_state", dut.state_q, ST_IDLE);
        check_eq("both_stop", stop, 1);
        check_eq("both_running", running, 0);
        check_eq("both_cnt", dut.cnt_q, 0);
        check_eq("both_sec", sec_count, 0);
        repeat (8) step();

        // Reset asserted mid-RUN at cnt=5 acts without a clock edge
        btn_start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) btn_start = 1'b0;
        end
        check_eq("rerun_running", running, 1);
        repeat (6) step();
        wait_sec("prerst_sec", 5);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_stop", stop, 1);
        check_eq("midrst_running", running, 0);
        check_eq("midrst_sec", sec_count, 0);
        check_eq("midrst_tick", tick, 0);
        check_eq("midrst_cnt", dut.cnt_q, 0);
        check_eq("midrst_state", dut.state_q, ST_IDLE);

        // Button held across reset release counts as a new press
        btn_start = 1'b1;
        step();
        step();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq($sformatf("held_press_%0d", k), dut.start_press_s, (k == 6) ? 1 : 0);
        end
        check_eq("held_running", running, 1);
        check_eq("held_sec", sec_count, 1);
        btn_start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 500000, meaning clk cycles per 10 ms count period at 50 MHz.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a button level (20 ms).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset (low = reset asserted, clears immediately, independent of clk).
REQ-005 The block SHALL have port btn_start, input, 1, raw asynchronous start/pause pushbutton, active-high.
REQ-006 The block SHALL have port btn_clear, input, 1, raw asynchronous clear pushbutton, active-high.
REQ-007 The block SHALL have port sec_count, output, 19, prescaler value for the digit counter stage.
REQ-008 The block SHALL have port stop, output, 1, digit-clear command for the digit counter stage.
REQ-009 The block SHALL have port running, output, 1, high while in RUN.
REQ-010 The block SHALL have port tick, output, 1, one-cycle pulse at each 10 ms boundary while running.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 The debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-013 A rising edge of a debounced level SHALL produce exactly one press pulse, one cycle wide; release SHALL produce nothing.
REQ-014 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-015 Transitions SHALL be: IDLE --start--> RUN; RUN --start--> PAUSE; PAUSE --start--> RUN; any state --clear--> IDLE.
REQ-016 When start and clear pulses coincide, clear SHALL win and the next state SHALL be IDLE.
REQ-017 The internal counter cnt SHALL count 0..CLK_DIV-1 and wrap to 0, incrementing only in RUN.
REQ-018 cnt SHALL be held in PAUSE and forced to 0 on entry to IDLE.
REQ-019 sec_count SHALL equal cnt in RUN and 0 otherwise, so the downstream stage never sees CLK_DIV-1 outside RUN.
REQ-020 tick SHALL be high only when the state is RUN and cnt == CLK_DIV-1.
REQ-021 stop SHALL be 1 in IDLE and 0 in RUN and PAUSE; running SHALL be 1 only in RUN.
REQ-022 All outputs SHALL be registered or decoded from registered state only, with no combinational path from button inputs.
REQ-023 On resume from PAUSE, counting SHALL continue from the held cnt value, with no extra or lost tick.

Reset
REQ-024 While reset is low: state = IDLE, cnt = 0, synchronizers = 0, debounced levels = 0, debounce counters = 0.
REQ-025 While reset is low, outputs SHALL be: stop = 1, running = 0, tick = 0, sec_count = 0.
REQ-026 A button held high across reset release SHALL be debounced as a new press, giving one start pulse after DEB_CYCLES + 2 cycles.

Structure
REQ-027 State encodings and the CLK_DIV and DEB_CYCLES defaults SHALL live in shared package stopwatch_pkg, used by stopwatch_ctrl and the digit counter stage.
REQ-028 Synchronizer, debounce and edge pulse logic SHALL be sub-module btn_debounce (ports clk, reset, btn_in, level, press), instantiated twice.

Verification (CLK_DIV=10, DEB_CYCLES=4)
REQ-029 The bench SHALL cover: reset low with buttons idle -> stop=1, sec_count=0, tick=0; after release, state IDLE.
REQ-030 The bench SHALL cover: btn_start high 8 cycles -> one press pulse at cycle 6, running=1, sec_count counts 0..9, tick high on 9, wraps to 0.
REQ-031 The bench SHALL cover: btn_start glitch of 3 cycles -> no press pulse, state unchanged.
REQ-032 The bench SHALL cover: press start while running at cnt=7 -> PAUSE, sec_count=0, stop=0; press again -> RUN resumes at cnt=7 or 8, next tick after the remaining cycles.
REQ-033 The bench SHALL cover: start and clear pressed so their pulses coincide -> IDLE, stop=1, cnt=0.
REQ-034 The bench SHALL cover: reset asserted mid-RUN at cnt=5 -> immediate IDLE, cnt=0, stop=1 without waiting for clk.
